irq_request_latch16: RTL
========================

# irq_request_latch16

Request-capture and handshake stage directly upstream of `priority_encoder16to4`. It conditions 16 raw request lines and keeps a pending register, with a per-line choice of rising-edge or level capture. The masked pending vector drives the 16-to-4 encoder. The resulting index is held stable and presented to the consumer with a valid/ready handshake. On acknowledge, the served edge-mode request is cleared.

## Interface
Parameters:
- `N_REQ`, 16: number of request lines. Fixed at 16 to match the encoder; other values are unsupported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 16: raw request lines. Already synchronous to `clk`.
- `edge_sel` in 16: per-line mode. 1 = rising-edge capture, 0 = level.
- `mask` in 16: per-line enable. 1 = eligible for arbitration.
- `clr_overrun` in 1: one-cycle pulse that clears all `overrun` bits.
- `irq_valid` out 1: an index is being presented.
- `irq_id` out 4: presented index. Highest set eligible line wins.
- `irq_ready` in 1: consumer accepts `irq_id` when high together with `irq_valid`.
- `pending` out 16: pending register, unmasked.
- `overrun` out 16: sticky. Set when an edge is lost on an already-pending line.

## Operation
- Reset values: `irq_valid`=0, `irq_id`=0, `pending`=0, `overrun`=0, state=IDLE. The internal previous-sample register `req_d` also resets to 0, so a line already high on the first post-reset cycle counts as a rising edge.
- Edge line (`edge_sel[i]`=1):
  - A rise is `req[i] & ~req_d[i]`; a rise sets `pending[i]`.
  - `pending[i]` is cleared only by a handshake on `irq_id`==i.
  - If a set and a clear hit the same bit in the same cycle, the set wins and no overrun is flagged.
  - A rise while `pending[i]`=1, with no clear in that cycle, sets `overrun[i]`.
- Level line (`edge_sel[i]`=0): `pending[i]` is loaded with `req[i]` every cycle. A handshake does not clear it. Overrun is never set for level lines.
- Changing `edge_sel[i]` takes effect on the next clock edge. The pending bit is not cleared by the switch.
- Eligible vector: `pending & mask`, fed to the encoder. Priority is index 15 highest down to index 0.
- State machine:
  - IDLE: `irq_valid`=0. If the eligible vector is non-zero, register the encoder output into `irq_id`, set `irq_valid`, and go to PRESENT.
  - PRESENT: `irq_valid`=1 and `irq_id` are frozen. On `irq_valid & irq_ready`: apply the edge-mode clear to `pending[irq_id]`, drop `irq_valid`, and return to IDLE.
- The presented id is never retracted or changed. This holds even if its line is masked, deasserts, or a higher-priority request arrives during PRESENT.
- `clr_overrun` clears all overrun bits. A new overrun in the same cycle wins.
- `rst` asserted in any state returns all state to reset values on that edge. An in-flight presentation is abandoned without a handshake.

## Timing
- Request sampled high at edge k sets `pending` after edge k (visible in cycle k+1).
- `irq_valid` rises after edge k+1, so latency from request to valid is 2 cycles.
- Handshake at edge h:
  - `irq_valid`=0 in cycle h+1 (at least one idle cycle between presentations).
  - The next `irq_valid` is visible at the earliest in cycle h+2.
- Peak throughput is one index every 2 cycles.
- `irq_ready` may be held high continuously. It is ignored when `irq_valid`=0.
- All outputs are registered. There is no combinational path from `irq_ready` to any output.

## Structure
- Shared package `irq_pkg`:
  - `N_REQ` = 16 and `ID_W` = 4.
  - State enum: `IDLE`, `PRESENT`.
  - Constants for `EDGE` = 1 and `LEVEL` = 0.
- One sub-module instance: the existing `priority_encoder16to4`, driven by `pending & mask`.
- The eligible-vector OR reduction lives in this block. It is not derived from the encoder.

## Test plan
- Reset release with `req`=16'h0001, `edge_sel`=16'hFFFF, `mask`=16'hFFFF → `pending[0]`=1 in cycle 1; `irq_valid`=1 with `irq_id`=0 in cycle 2.
- Edge rises on lines 3 and 12 in the same cycle, `irq_ready` held 1 → first `irq_id`=12, valid low for one cycle, then `irq_id`=3; `pending` ends at 0.
- Line 5 in level mode held high, `irq_ready` held 1 → `irq_id`=5 is presented every 2 cycles. Deassert `req[5]` → at most one further presentation, then `irq_valid` stays 0.
- Edge-mode line 7 presented with `irq_ready`=0, then a new rise on line 7 → `overrun[7]`=1. A handshake in the same cycle as a rise instead leaves `pending[7]`=1 and `overrun[7]`=0.
- `mask`=16'h00FF with `pending`=16'h8010 → `irq_id`=4. Unmask bit 15 during PRESENT → `irq_id` stays 4 until the handshake, then 15 is presented.
- `rst` pulsed while in PRESENT → the next cycle has `irq_valid`=0, `pending`=0, `overrun`=0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request latch and its priority encoder.
package irq_pkg;

  localparam int N_REQ = 16;
  localparam int ID_W  = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_e;

  // Values of edge_sel per line.
  localparam logic EDGE  = 1'b1;
  localparam logic LEVEL = 1'b0;

endpackage

// File: rtl/priority_encoder16to4.sv
// 16-to-4 priority encoder: index of the highest set request bit, 0 when none are set.
module priority_encoder16to4
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  output logic [ID_W-1:0]  o_id
);

  // Ascending scan so the last (highest) set bit is the one that sticks.
  always_comb begin
    o_id = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_req[i]) o_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_request_latch16.sv
// Request capture (per-line edge or level), pending/overrun tracking and a
// registered valid/ready presentation of the highest-priority eligible index.
module irq_request_latch16
  import irq_pkg::*;
#(
  parameter int N_REQ = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] edge_sel,
  input  logic [N_REQ-1:0] mask,
  input  logic             clr_overrun,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ready,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] overrun,
  output irq_state_e       dbg_state
);

  // Handshake: a transfer happens on a rising edge where irq_valid & irq_ready.
  // Once irq_valid is high, irq_id holds until that transfer; irq_ready is a
  // don't-care while irq_valid is low.

  logic [N_REQ-1:0] r_req_d;
  logic [N_REQ-1:0] r_pending;
  logic [N_REQ-1:0] r_overrun;
  logic             r_irq_valid;
  logic [ID_W-1:0]  r_irq_id;
  irq_state_e       r_state;

  logic [N_REQ-1:0] w_rise;
  logic [N_REQ-1:0] w_clr;
  logic [N_REQ-1:0] w_elig;
  logic [N_REQ-1:0] w_pend_nxt;
  logic [N_REQ-1:0] w_ovr_set;
  logic [ID_W-1:0]  w_enc_id;
  logic             w_hs;
  logic             w_any;

  priority_encoder16to4 u_enc (
    .i_req (w_elig),
    .o_id  (w_enc_id)
  );

  always_comb begin
    w_rise = req & ~r_req_d;
    w_hs   = r_irq_valid & irq_ready;
    w_clr  = '0;
    if (w_hs) w_clr[r_irq_id] = 1'b1;
    w_elig = r_pending & mask;
    w_any  = |w_elig;
    // Edge lines: a new rise beats a same-cycle clear. Level lines follow req.
    w_pend_nxt = (edge_sel & (w_rise | (r_pending & ~w_clr))) | (~edge_sel & req);
    w_ovr_set  = edge_sel & w_rise & r_pending & ~w_clr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_d     <= '0;
      r_pending   <= '0;
      r_overrun   <= '0;
      r_irq_valid <= 1'b0;
      r_irq_id    <= '0;
      r_state     <= IDLE;
    end else begin
      r_req_d   <= req;
      r_pending <= w_pend_nxt;
      r_overrun <= (clr_overrun ? '0 : r_overrun) | w_ovr_set;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_irq_id    <= w_enc_id;
            r_irq_valid <= 1'b1;
            r_state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ready) begin
            r_irq_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_irq_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid = r_irq_valid;
  assign irq_id    = r_irq_id;
  assign pending   = r_pending;
  assign overrun   = r_overrun;
  assign dbg_state = r_state;

endmodule
